// File: rtl/uart_rx_if.sv
// uart_rx_if: byte handshake between the UART receiver and its consumer.
//   rx_data  receiver -> consumer  last correctly framed byte
//   rdy      receiver -> consumer  a new byte is waiting in rx_data
//   frm_err  receiver -> consumer  last frame had a low stop bit
//   ovr_err  receiver -> consumer  a byte was overwritten before acknowledge
//   clr_rdy  consumer -> receiver  acknowledge (pulse or level)
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr_err;
  logic       clr_rdy;

  modport master (output rx_data, rdy, frm_err, ovr_err, input clr_rdy);
  modport slave  (input rx_data, rdy, frm_err, ovr_err, output clr_rdy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver feeding the authorization FSM.
// Samples each bit at mid-bit with a down-counting baud timer, flags false
// starts, framing errors and overruns, and hands bytes over with rdy/clr_rdy.
//   clk  in   system clock, rising edge
//   rst  in   synchronous active-high reset
//   RX   in   asynchronous serial line, idles high
//   bus  uart_rx_if.master  rx_data/rdy/frm_err/ovr_err out, clr_rdy in
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronized line
// START | timing half a bit to re-check the start bit
// DATA  | sampling 8 data bits, LSB first
// STOP  | sampling the stop bit, publishing the byte or a framing error
module uart_rx #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      RX,
  uart_rx_if.master bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [11:0] HALF_BIT = 12'(BAUD_DIV / 2);
  localparam logic [11:0] FULL_BIT = 12'(BAUD_DIV);

  state_t      state;
  logic        rx_m;
  logic        rx_s;
  logic        rx_q;
  logic [11:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  rx_data_r;
  logic        rdy_r;
  logic        frm_err_r;
  logic        ovr_err_r;
  logic        expire;
  logic        good_stop;

  // A load of N makes the counter read 1 in the Nth cycle after the load.
  assign expire    = (baud_cnt == 12'd1);
  assign good_stop = (state == STOP) && expire && rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      rx_q      <= 1'b1;
      baud_cnt  <= 12'd0;
      bit_cnt   <= 4'd0;
      shreg     <= 8'h00;
      rx_data_r <= 8'h00;
      rdy_r     <= 1'b0;
      frm_err_r <= 1'b0;
      ovr_err_r <= 1'b0;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
      rx_q <= rx_s;

      if (baud_cnt != 12'd0) baud_cnt <= baud_cnt - 12'd1;

      // A good stop bit wins over a simultaneous acknowledge: the new byte
      // is flagged ready and the acknowledge only suppresses the overrun.
      if (good_stop) begin
        rx_data_r <= shreg;
        rdy_r     <= 1'b1;
        ovr_err_r <= bus.clr_rdy ? 1'b0 : (ovr_err_r | rdy_r);
      end else if (bus.clr_rdy) begin
        rdy_r     <= 1'b0;
        ovr_err_r <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rx_q && !rx_s) begin
            baud_cnt  <= HALF_BIT;
            frm_err_r <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (expire) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              baud_cnt <= FULL_BIT;
              bit_cnt  <= 4'd0;
              state    <= DATA;
            end
          end
        end
        DATA: begin
          if (expire) begin
            shreg    <= {rx_s, shreg[7:1]};
            bit_cnt  <= bit_cnt + 4'd1;
            baud_cnt <= FULL_BIT;
            if (bit_cnt == 4'd7) state <= STOP;
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit lets an immediate next start edge be seen;
          // a line still low needs to go high before rx_q/rx_s can re-arm.
          if (expire) begin
            if (!rx_s) frm_err_r <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_data = rx_data_r;
  assign bus.rdy     = rdy_r;
  assign bus.frm_err = frm_err_r;
  assign bus.ovr_err = ovr_err_r;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  localparam int BD      = 16;
  localparam int FRAME   = 10 * BD;
  localparam int EXP_LAT = 2 + BD / 2 + 9 * BD + 1;
  localparam int STOP_CY = EXP_LAT - 1;
  localparam int NONE    = -10;

  logic clk;
  logic rst;
  logic RX;
  uart_rx_if bus ();

  uart_rx #(.BAUD_DIV(BD)) dut (
    .clk(clk),
    .rst(rst),
    .RX (RX),
    .bus(bus)
  );

  int n_tests;
  int n_fail;

  // Behavioural model of the consumer-visible outputs, updated per frame.
  logic [7:0] m_data;
  logic       m_rdy;
  logic       m_frm;
  logic       m_ovr;

  logic [10:0] snap;
  logic [7:0]  got_q[$];
  bit          err_seen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [10:0] obs();
    return {bus.rx_data, bus.rdy, bus.frm_err, bus.ovr_err};
  endfunction

  function automatic logic [10:0] mdl();
    return {m_data, m_rdy, m_frm, m_ovr};
  endfunction

  function automatic void model_reset();
    m_data = 8'h00; m_rdy = 1'b0; m_frm = 1'b0; m_ovr = 1'b0;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input bit ok, input bit ack);
    m_frm = 1'b0;
    if (ok) begin
      m_ovr  = ack ? 1'b0 : (m_ovr | m_rdy);
      m_rdy  = 1'b1;
      m_data = b;
    end else begin
      m_frm = 1'b1;
      if (ack) begin m_rdy = 1'b0; m_ovr = 1'b0; end
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    tick(n);
  endtask

  task automatic do_ack();
    bus.clr_rdy = 1'b1;
    tick(1);
    bus.clr_rdy = 1'b0;
    m_rdy = 1'b0;
    m_ovr = 1'b0;
  endtask

  // Drives one 8N1 frame; cycle 0 is the pin fall of the start bit.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int ack_at,
                            input int rst_at, input int snap_at, input bit auto_ack,
                            output int lat);
    logic [9:0] bits;
    bit prev_rdy;
    bits = {stop_ok, b, 1'b0};
    lat = -1;
    prev_rdy = bus.rdy;
    for (int cyc = 0; cyc < FRAME; cyc++) begin
      if (cyc % BD == 0) RX = bits[cyc / BD];
      if (!prev_rdy && bus.rdy && lat < 0) lat = cyc;
      prev_rdy = bus.rdy;
      if (cyc == ack_at) bus.clr_rdy = 1'b1;
      else if (cyc == ack_at + 1) bus.clr_rdy = 1'b0;
      if (cyc == rst_at) rst = 1'b1;
      else if (cyc == rst_at + 1) rst = 1'b0;
      if (cyc == snap_at) snap = obs();
      if (auto_ack) begin
        err_seen = err_seen | bus.frm_err | bus.ovr_err;
        if (bus.clr_rdy) bus.clr_rdy = 1'b0;
        else if (bus.rdy) begin
          got_q.push_back(bus.rx_data);
          bus.clr_rdy = 1'b1;
        end
      end
      tick(1);
    end
    RX = 1'b1;
  endtask

  task automatic test_reset();
    RX = 1'b1;
    bus.clr_rdy = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    model_reset();
    n_tests++;
    if (obs() !== mdl()) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h", obs(), mdl());
    end
    idle(40);
    n_tests++;
    if (obs() !== mdl()) begin
      n_fail++;
      $display("FAIL reset_idle_quiet: got %h want %h", obs(), mdl());
    end
  endtask

  task automatic test_single();
    int lat;
    send_frame(8'hA5, 1'b1, NONE, NONE, NONE, 1'b0, lat);
    model_frame(8'hA5, 1'b1, 1'b0);
    n_tests++;
    if (lat < EXP_LAT - 1 || lat > EXP_LAT + 1) begin
      n_fail++;
      $display("FAIL single_latency: got %0d want %0d+-1", lat, EXP_LAT);
    end
    n_tests++;
    if (obs() !== mdl()) begin
      n_fail++;
      $display("FAIL single_byte: got %h want %h", obs(), mdl());
    end
    do_ack();
    n_tests++;
    if (obs() !== mdl()) begin
      n_fail++;
      $display("FAIL single_ack: got %h want %h", obs(), mdl());
    end
    idle(5);
  endtask

  task automatic test_false_start();
    int lat;
    RX = 1'b0;
    tick(5);
    idle(3 * BD);
    n_tests++;
    if (obs() !== mdl()) begin
      n_fail++;
      $display("FAIL false_start: got %h want %h", obs(), mdl());
    end
    send_frame(8'h3C, 1'b1, NONE, NONE, NONE, 1'b0, lat);
    model_frame(8'h3C, 1'b1, 1'b0);
    n_tests++;
    if (obs() !== mdl()) begin
      n_fail++;
      $display("FAIL after_false_start: got %h want %h", obs(), mdl());
    end
    idle(3);
  endtask

  task automatic test_framing();
    int lat;
    do_ack();
    send_frame(8'h81, 1'b0, NONE, NONE, NONE, 1'b0, lat);
    model_frame(8'h81, 1'b0, 1'b0);
    idle(4);
    n_tests++;
    if (obs() !== mdl()) begin
      n_fail++;
      $display("FAIL framing_err: got %h want %h", obs(), mdl());
    end
    send_frame(8'h42, 1'b1, NONE, NONE, 10, 1'b0, lat);
    n_tests++;
    if (snap[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL frm_clear_at_start: got %b want 0", snap[1]);
    end
    model_frame(8'h42, 1'b1, 1'b0);
    n_tests++;
    if (obs() !== mdl()) begin
      n_fail++;
      $display("FAIL after_framing: got %h want %h", obs(), mdl());
    end
    idle(3);
  endtask

  task automatic test_overrun();
    int lat;
    do_ack();
    send_frame(8'h11, 1'b1, NONE, NONE, NONE, 1'b0, lat);
    model_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, NONE, NONE, NONE, 1'b0, lat);
    model_frame(8'h22, 1'b1, 1'b0);
    n_tests++;
    if (obs() !== mdl()) begin
      n_fail++;
      $display("FAIL overrun_set: got %h want %h", obs(), mdl());
    end
    do_ack();
    n_tests++;
    if (obs() !== mdl()) begin
      n_fail++;
      $display("FAIL overrun_clear: got %h want %h", obs(), mdl());
    end
    idle(3);
    send_frame(8'h11, 1'b1, NONE, NONE, NONE, 1'b0, lat);
    model_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, STOP_CY, NONE, NONE, 1'b0, lat);
    model_frame(8'h22, 1'b1, 1'b1);
    n_tests++;
    if (obs() !== mdl()) begin
      n_fail++;
      $display("FAIL ack_on_stop: got %h want %h", obs(), mdl());
    end
    idle(3);
  endtask

  task automatic test_reset_mid();
    int lat;
    // rdy is still set from the previous test, so the reset has work to do
    send_frame(8'hFF, 1'b1, NONE, 5 * BD + 8, 5 * BD + 9, 1'b0, lat);
    model_reset();
    n_tests++;
    if (snap !== mdl()) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h want %h", snap, mdl());
    end
    n_tests++;
    if (obs() !== mdl()) begin
      n_fail++;
      $display("FAIL reset_mid_discard: got %h want %h", obs(), mdl());
    end
    idle(3);
    send_frame(8'h5A, 1'b1, NONE, NONE, NONE, 1'b0, lat);
    model_frame(8'h5A, 1'b1, 1'b0);
    n_tests++;
    if (obs() !== mdl()) begin
      n_fail++;
      $display("FAIL after_reset_mid: got %h want %h", obs(), mdl());
    end
    do_ack();
    idle(3);
  endtask

  task automatic test_stream();
    int lat;
    logic [7:0] exp_q[$];
    got_q.delete();
    err_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back((i % 2 == 0) ? 8'h00 : 8'hFF);
      send_frame(exp_q[i], 1'b1, NONE, NONE, NONE, 1'b1, lat);
    end
    idle(4);
    bus.clr_rdy = 1'b0;
    n_tests++;
    if (got_q.size() != 20) begin
      n_fail++;
      $display("FAIL stream_count: got %0d want 20", got_q.size());
    end
    for (int i = 0; i < 20 && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stream_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_tests++;
    if (err_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_errors: got %b want 0", err_seen);
    end
    model_reset();
    n_tests++;
    if (obs() !== {8'hFF, 3'b000}) begin
      n_fail++;
      $display("FAIL stream_final: got %h want %h", obs(), {8'hFF, 3'b000});
    end
    m_data = 8'hFF;
  endtask

  task automatic test_random();
    int lat;
    bit prev_bad;
    prev_bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      logic [7:0] b;
      bit ok;
      bit ack_stop;
      int gap;
      b = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 99) < 80);
      ack_stop = ($urandom_range(0, 99) < 20);
      gap = $urandom_range(0, 12);
      if (prev_bad && gap < 2) gap = 2;
      if (gap > 0) idle(gap);
      if ($urandom_range(0, 1) == 1 && gap > 0) do_ack();
      send_frame(b, ok, ack_stop ? STOP_CY : NONE, NONE, NONE, 1'b0, lat);
      model_frame(b, ok, ack_stop);
      n_tests++;
      if (obs() !== mdl()) begin
        n_fail++;
        $display("FAIL random_frame%0d: got %h want %h (byte %h ok %0d ack %0d)",
                 i, obs(), mdl(), b, ok, ack_stop);
      end
      prev_bad = !ok;
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    RX = 1'b1;
    bus.clr_rdy = 1'b0;
    snap = '0;
    err_seen = 1'b0;
    model_reset();
    tick(2);
    test_reset();
    test_single();
    test_false_start();
    test_framing();
    test_overrun();
    test_reset_mid();
    test_stream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
